// File: rtl/data_bus_buffer_fifo.sv
// Clocked PIC data bus buffer: captured CPU writes queue in a show-ahead FIFO; reads request data from control and drive Ds.
// Define DBB_PROTO_ERR_EN to add the proto_err output (simultaneous strobes or a dropped write).
module data_bus_buffer_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 4,
    parameter int READ_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [DATA_WIDTH-1:0] Ds,
    input  logic                  RD_flag,
    input  logic                  WR_flag,
    input  logic [DATA_WIDTH-1:0] Ds_from_control,
    input  logic                  ctrl_rd_valid,
    output logic                  RD_flag_control,
    output logic [DATA_WIDTH-1:0] Ds_to_Control,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  rd_timeout
`ifdef DBB_PROTO_ERR_EN
    ,
    output logic                  proto_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(READ_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DRIVE
    } rd_state_t;

    logic                  r_rd_prev, r_wr_prev;
    logic [DATA_WIDTH-1:0] r_wr_hold;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_head;
    logic                  r_overflow;

    rd_state_t             r_state;
    logic                  r_rd_req;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [TW-1:0]         r_to_cnt;
    logic                  r_rd_timeout;

    logic                  w_wr_fall, w_rd_rise;
    logic                  w_full, w_empty, w_pop, w_push, w_drop, w_rd_drive;
    logic [AW-1:0]         w_rd_ptr_nxt;
    logic [CW-1:0]         w_level_after_pop;
    logic [DATA_WIDTH-1:0] w_head_nxt;

    assign w_wr_fall         = r_wr_prev & ~WR_flag;
    assign w_rd_rise         = RD_flag & ~r_rd_prev;
    assign w_full            = (r_count == CW'(DEPTH));
    assign w_empty           = (r_count == '0);
    assign w_pop             = ~w_empty & wr_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push            = w_wr_fall & (~w_full | w_pop);
    assign w_drop            = w_wr_fall & w_full & ~w_pop;
    assign w_rd_ptr_nxt      = r_rd_ptr + AW'(w_pop);
    assign w_level_after_pop = r_count - CW'(w_pop);

    // Show-ahead head: next stored entry, else the entry being pushed into an empty FIFO, else hold.
    always_comb begin
        w_head_nxt = r_head;
        if (w_level_after_pop != '0)
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        else if (w_push)
            w_head_nxt = r_wr_hold;
    end

    // NOTE: storage array has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_wr_hold;
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_prev  <= 1'b0;
            r_wr_prev  <= 1'b0;
            r_wr_hold  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_prev <= RD_flag;
            r_wr_prev <= WR_flag;
            if (WR_flag)
                r_wr_hold <= Ds;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_head   <= w_head_nxt;
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rd_req     <= 1'b0;
            r_rd_data    <= '0;
            r_to_cnt     <= '0;
            r_rd_timeout <= 1'b0;
        end else begin
            r_rd_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_rise && !WR_flag) begin
                        r_state  <= ST_RD_REQ;
                        r_rd_req <= 1'b1;
                        r_to_cnt <= '0;
                    end
                end
                ST_RD_REQ: begin
                    if (!RD_flag || WR_flag) begin
                        r_state  <= ST_IDLE;
                        r_rd_req <= 1'b0;
                    end else if (ctrl_rd_valid) begin
                        r_rd_data <= Ds_from_control;
                        r_state   <= ST_RD_DRIVE;
                        r_rd_req  <= 1'b0;
                    end else if (r_to_cnt == TW'(READ_TIMEOUT - 1)) begin
                        r_rd_data    <= '1;
                        r_rd_timeout <= 1'b1;
                        r_state      <= ST_RD_DRIVE;
                        r_rd_req     <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                ST_RD_DRIVE: begin
                    if (!RD_flag || WR_flag)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_rd_req <= 1'b0;
                end
            endcase
        end
    end

    // Drive gate uses the live strobes so the bus is released in the cycle RD_flag drops or WR_flag rises.
    assign w_rd_drive = (r_state == ST_RD_DRIVE) & RD_flag & ~WR_flag;
    assign Ds         = w_rd_drive ? r_rd_data : {DATA_WIDTH{1'bz}};

    assign RD_flag_control = r_rd_req;
    assign Ds_to_Control   = r_head;
    assign wr_valid        = ~w_empty;
    assign fifo_full       = w_full;
    assign overflow        = r_overflow;
    assign rd_timeout      = r_rd_timeout;

`ifdef DBB_PROTO_ERR_EN
    logic r_proto_err;

    always_ff @(posedge clk) begin
        if (reset)
            r_proto_err <= 1'b0;
        else
            r_proto_err <= (RD_flag & WR_flag) | w_drop;
    end

    assign proto_err = r_proto_err;
`endif

endmodule
